// File: rtl/lsu_mem_access.sv
// lsu_mem_access: single-outstanding load/store unit in front of a 64-bit data
// memory with registered, 1-cycle read latency. Sub-dword stores are done as
// read-modify-write of the containing doubleword.
// Optional build macro LSU_ALIGN_CHECK_EN: misaligned requests are answered
// with resp_err instead of being truncated to the size boundary.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RD    | mem_read pulse for the addressed doubleword
// CAP   | read data on mem_rdata; extract (load) or merge (sub-dword store)
// WR    | mem_write pulse with full or merged doubleword
// RESP  | response held until resp_ready
module lsu_mem_access #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t state_q, state_d;

  logic              accept;
  logic [2:0]        low_mask;
  logic [2:0]        lane;
  logic              misalign_err;
  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [2:0]        lane_q;
  logic [DATA_W-1:0] rd_shifted;
  logic [DATA_W-1:0] wd_shifted;
  logic [DATA_W-1:0] extracted;
  logic [DATA_W-1:0] merged;
  logic [7:0]        byte_en;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // Address bits below the access size; cleared to form the byte lane.
  always_comb begin
    low_mask = 3'b000;
    case (req_size)
      2'd0:    low_mask = 3'b000;
      2'd1:    low_mask = 3'b001;
      2'd2:    low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
  end

  assign lane = req_addr[2:0] & ~low_mask;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign_err = |(req_addr[2:0] & low_mask);
`else
  assign misalign_err = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misalign_err)                  state_d = RESP;
          else if (req_we && req_size == 2'd3) state_d = WR;
          else                               state_d = RD;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Load extraction and store merge from the captured doubleword.
  always_comb begin
    rd_shifted = mem_rdata >> {lane_q, 3'b000};
    wd_shifted = mem_wdata << {lane_q, 3'b000};
    extracted  = rd_shifted;
    byte_en    = 8'hFF;
    case (size_q)
      2'd0: begin
        extracted = {{(DATA_W-8){signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
        byte_en   = 8'h01 << lane_q;
      end
      2'd1: begin
        extracted = {{(DATA_W-16){signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
        byte_en   = 8'h03 << lane_q;
      end
      2'd2: begin
        extracted = {{(DATA_W-32){signed_q & rd_shifted[31]}}, rd_shifted[31:0]};
        byte_en   = 8'h0F << lane_q;
      end
      default: begin
        extracted = rd_shifted;
        byte_en   = 8'hFF;
      end
    endcase
    merged = mem_rdata;
    for (int b = 0; b < 8; b++) begin
      if (byte_en[b]) merged[8*b +: 8] = wd_shifted[8*b +: 8];
    end
  end

  // Registered outputs and latched request. mem_wdata doubles as the holding
  // register for store data until the merge in CAP overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      signed_q   <= 1'b0;
      lane_q     <= 3'd0;
    end else begin
      mem_read   <= (state_d == RD);
      mem_write  <= (state_d == WR);
      resp_valid <= (state_d == RESP);
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q       <= req_we;
            size_q     <= req_size;
            signed_q   <= req_signed;
            lane_q     <= lane;
            resp_err   <= misalign_err;
            resp_rdata <= '0;
            if (!misalign_err) begin
              mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
              mem_wdata <= req_wdata;
            end
          end
        end
        CAP: begin
          if (we_q) mem_wdata  <= merged;
          else      resp_rdata <= extracted;
        end
        RESP: begin
          if (resp_ready) begin
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// tb_lsu_mem_access: directed plus randomized accesses against a byte-array
// reference memory; a simple registered-read memory model sits on the mem port.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  ref_mem [0:255];
  logic [63:0] mem     [0:31];

  always #5 clk = ~clk;

  lsu_mem_access #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Data memory: registered read, write on strobe.
  always @(posedge clk) begin
    if (mem_read)  mem_rdata <= mem[mem_addr[7:3]];
    if (mem_write) mem[mem_addr[7:3]] = mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_dword(input int a);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[(a & ~7) + i];
    return v;
  endfunction

  function automatic logic [63:0] ref_load(input int ea, input int n, input logic sgn);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[ea + i];
    if (sgn && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  task automatic poke_dword(input int a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) ref_mem[a + i] = v[8*i +: 8];
    mem[a >> 3] = v;
  endtask

  // One complete transaction with timing, data and handshake checks.
  task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                           input int addr, input logic [63:0] wdata, input int hold,
                           output logic [63:0] rdata_obs);
    int n, ea, exp_resp, resp_k;
    logic err_exp, got_resp;
    logic [15:0] exp_rd, exp_wr, rd_mask, wr_mask;
    logic [63:0] exp_rdata, exp_wd, wd_obs;
    n        = 1 << size;
    ea       = addr & ~(n - 1);
    err_exp  = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    err_exp  = (addr % n) != 0;
`endif
    exp_rdata = '0; exp_wd = '0; exp_rd = '0; exp_wr = '0;
    if (err_exp) begin
      exp_resp = 1;
    end else if (!we) begin
      exp_rd = 16'h0002; exp_resp = 3;
      exp_rdata = ref_load(ea, n, sgn);
    end else begin
      for (int i = 0; i < n; i++) ref_mem[ea + i] = wdata[8*i +: 8];
      exp_wd = ref_dword(ea);
      if (n == 8) begin exp_wr = 16'h0002; exp_resp = 2; end
      else begin exp_rd = 16'h0002; exp_wr = 16'h0008; exp_resp = 4; end
    end

    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn;
    req_addr = 64'(addr); req_wdata = wdata; req_valid = 1'b1;
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    rd_mask = '0; wr_mask = '0; wd_obs = '0; got_resp = 1'b0; resp_k = 0;
    for (int k = 1; k <= 12 && !got_resp; k++) begin
      if (mem_read)  rd_mask |= 16'd1 << k;
      if (mem_write) begin wr_mask |= 16'd1 << k; wd_obs = mem_wdata; end
      if (k == 1 && !err_exp) check("mem_addr", mem_addr, 64'(ea & ~7));
      if (resp_valid) begin got_resp = 1'b1; resp_k = k; end
      else @(negedge clk);
    end
    rdata_obs = resp_rdata;
    if (!got_resp) begin
      check("resp_timeout", 64'd0, 64'd1);
      return;
    end
    check("resp_cycle", 64'(resp_k), 64'(exp_resp));
    check("mem_read_cycles", {48'd0, rd_mask}, {48'd0, exp_rd});
    check("mem_write_cycles", {48'd0, wr_mask}, {48'd0, exp_wr});
    if (exp_wr != 0) check("mem_wdata", wd_obs, exp_wd);
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_err", {63'd0, resp_err}, {63'd0, err_exp});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_ctrl", {59'd0, resp_valid, req_ready, mem_read, mem_write, resp_err},
            {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, err_exp});
      check("hold_rdata", resp_rdata, exp_rdata);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_resp", {62'd0, resp_valid, req_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] r;
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_we = 1'b0;
    req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    for (int a = 0; a < 256; a += 8) poke_dword(a, {$urandom, $urandom});
    poke_dword(16, 64'h8877665544332211);

    repeat (3) @(negedge clk);
    check("rst_ctrl", {58'd0, req_ready, resp_valid, resp_err, mem_read, mem_write, 1'b0},
          {58'd0, 6'b100000});
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ctrl", {62'd0, req_ready, resp_valid}, 64'd2);

    do_access(1'b0, 2'd0, 1'b1, 16'h17, '0, 0, r);
    check("lb_signed", r, 64'hFFFFFFFFFFFFFF88);
    do_access(1'b0, 2'd0, 1'b0, 16'h17, '0, 1, r);
    check("lb_unsigned", r, 64'h0000000000000088);
    do_access(1'b0, 2'd1, 1'b1, 16'h12, '0, 0, r);
    check("lh_signed", r, 64'h0000000000004433);
    do_access(1'b0, 2'd2, 1'b1, 16'h14, '0, 0, r);
    check("lw_signed", r, 64'hFFFFFFFF88776655);
    do_access(1'b1, 2'd0, 1'b0, 16'h11, 64'h00000000000000AB, 0, r);
    do_access(1'b0, 2'd3, 1'b0, 16'h10, '0, 0, r);
    check("ld_after_sb", r, 64'h887766554433AB11);
    do_access(1'b1, 2'd3, 1'b0, 16'h20, 64'hDEADBEEFCAFEF00D, 5, r);
    check("sd_rdata", r, 64'd0);
    check("sd_mem", mem[4], 64'hDEADBEEFCAFEF00D);
    do_access(1'b0, 2'd1, 1'b1, 16'h13, '0, 0, r);

    // Reset asserted in T+2 of a byte store: the write must never happen.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 64'h11; req_wdata = 64'hCD; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_t1_write", {63'd0, mem_write}, 64'd0);
    @(negedge clk);
    check("abort_t2_write", {63'd0, mem_write}, 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_rst_ctrl", {60'd0, req_ready, resp_valid, mem_read, mem_write}, 64'd8);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_write", {63'd0, mem_write}, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_release", {62'd0, req_ready, resp_valid}, 64'd2);
    check("abort_mem", mem[2], 64'h887766554433AB11);
    do_access(1'b0, 2'd3, 1'b0, 16'h10, '0, 0, r);
    check("abort_reload", r, 64'h887766554433AB11);

    for (int t = 0; t < 40; t++) begin
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                {$urandom, $urandom}, int'($urandom_range(0, 2)), r);
    end
    for (int a = 0; a < 256; a += 8) check("final_mem", mem[a >> 3], ref_dword(a));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
